// File: rtl/w25q_pkg.sv
// Shared constants and types for the W25Q fast-read request arbiter.
package w25q_pkg;

    localparam int ADDR_W_DEF  = 24;
    localparam int TIMEOUT_DEF = 1024;
    localparam int RSP_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// the previous accepted transaction is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       arstn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant_q;

    // Grant the lone requester, or on a tie the one that lost last time
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    // Remember who won; reset to 1 so requester 0 takes the first tie
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            last_grant_q <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant_q <= gnt[1];
        end
    end

endmodule

// File: rtl/w25q_read_arbiter.sv
// Arbitrates two read requesters onto the single W25Q fast-read engine,
// sequences the start/done handshake and returns the two data bytes as a
// one-cycle response, with a watchdog for an engine that never finishes.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | waiting for a request, arbiter drives ready
// ST_START     | fr_start high, watchdog cleared
// ST_WAIT_DONE | counting, waiting for a fresh rising edge on fr_done
// ST_WAIT_LOW  | response issued, waiting for the engine to drop fr_done
module w25q_read_arbiter
    import w25q_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [RSP_W-1:0]  rsp0_data,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [RSP_W-1:0]  rsp1_data,
    output logic              rsp1_err,
    output logic              fr_start,
    output logic [ADDR_W-1:0] fr_addr,
    input  logic              fr_done,
    input  logic [7:0]        fr_data1,
    input  logic [7:0]        fr_data2,
    output logic              busy,
    output logic              grant
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              fr_start_q;
    logic [ADDR_W-1:0] fr_addr_q;
    logic              grant_q;
    logic [1:0]        rsp_valid_q;
    logic [1:0]        rsp_err_q;
    logic [RSP_W-1:0]  rsp_data_q [2];

    logic [1:0] gnt;
    logic       idle;
    logic       accept;
    logic       done_rise;

    assign idle      = (state_q == ST_IDLE);
    assign accept    = idle && (gnt != 2'b00);
    assign done_rise = fr_done && !done_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .arstn   (arstn),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    assign req0_ready = idle && gnt[0];
    assign req1_ready = idle && gnt[1];

    assign fr_start   = fr_start_q;
    assign fr_addr    = fr_addr_q;
    assign grant      = grant_q;
    assign busy       = !idle;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp0_data  = rsp_data_q[0];
    assign rsp1_data  = rsp_data_q[1];

    // Sequencer: accept, start pulse, wait for done edge or watchdog, drain done
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            fr_start_q    <= 1'b0;
            fr_addr_q     <= '0;
            grant_q       <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= '0;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
        end else begin
            // done history runs in every state so a done already high at
            // START is never mistaken for a completion edge
            done_q      <= fr_done;
            fr_start_q  <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        fr_addr_q  <= gnt[1] ? req1_addr : req0_addr;
                        grant_q    <= gnt[1];
                        fr_start_q <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (done_rise) begin
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q[grant_q]   <= 1'b0;
                        rsp_data_q[grant_q]  <= {fr_data1, fr_data2};
                        state_q              <= ST_WAIT_LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q[grant_q]   <= 1'b1;
                        rsp_data_q[grant_q]  <= '0;
                        state_q              <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!fr_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w25q_read_arbiter.sv
// Directed bench for w25q_read_arbiter: a main instance with the default
// watchdog and a second instance with TIMEOUT=16 for the watchdog path.
module tb_w25q_read_arbiter;

    localparam int AW = 24;

    logic          clk;
    logic          arstn;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [15:0]   rsp0_data, rsp1_data;
    logic          rsp0_err, rsp1_err;
    logic          fr_start;
    logic [AW-1:0] fr_addr;
    logic          fr_done;
    logic [7:0]    fr_data1, fr_data2;
    logic          busy, grant;

    logic          t_req0_valid, t_req1_valid;
    logic [AW-1:0] t_req0_addr, t_req1_addr;
    logic          t_req0_ready, t_req1_ready;
    logic          t_rsp0_valid, t_rsp1_valid;
    logic [15:0]   t_rsp0_data, t_rsp1_data;
    logic          t_rsp0_err, t_rsp1_err;
    logic          t_fr_start;
    logic [AW-1:0] t_fr_addr;
    logic          t_fr_done;
    logic [7:0]    t_fr_data1, t_fr_data2;
    logic          t_busy, t_grant;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] q0[$];
    logic [AW-1:0] q1[$];

    int            rsp0_n = 0, rsp1_n = 0, start_n = 0;
    logic [15:0]   rsp0_last, rsp1_last;
    logic          rsp0_err_last, rsp1_err_last;
    int            rsp0_cyc, rsp1_cyc;
    logic [AW-1:0] addr_log[$];
    logic          grant_log[$];
    int            start_cyc_log[$];

    int            eng_lat   = 5;
    int            eng_hold  = 2;
    bit            eng_fixed = 0;
    logic [7:0]    eng_d1    = 8'h00;
    logic [7:0]    eng_d2    = 8'h00;
    bit            eng_busy  = 0;
    logic [AW-1:0] eng_a;
    int            rise_log[$];
    int            fall_log[$];

    w25q_read_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .arstn(arstn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .fr_start(fr_start), .fr_addr(fr_addr), .fr_done(fr_done),
        .fr_data1(fr_data1), .fr_data2(fr_data2), .busy(busy), .grant(grant)
    );

    w25q_read_arbiter #(.ADDR_W(AW), .TIMEOUT(16)) dut_t (
        .clk(clk), .arstn(arstn),
        .req0_valid(t_req0_valid), .req0_addr(t_req0_addr), .req0_ready(t_req0_ready),
        .req1_valid(t_req1_valid), .req1_addr(t_req1_addr), .req1_ready(t_req1_ready),
        .rsp0_valid(t_rsp0_valid), .rsp0_data(t_rsp0_data), .rsp0_err(t_rsp0_err),
        .rsp1_valid(t_rsp1_valid), .rsp1_data(t_rsp1_data), .rsp1_err(t_rsp1_err),
        .fr_start(t_fr_start), .fr_addr(t_fr_addr), .fr_done(t_fr_done),
        .fr_data1(t_fr_data1), .fr_data2(t_fr_data2), .busy(t_busy), .grant(t_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // requester 0: present head of queue, pop it on the accepting edge
    initial begin
        req0_valid = 1'b0;
        req0_addr  = '0;
        forever begin
            @(negedge clk);
            req0_valid = (q0.size() != 0);
            req0_addr  = (q0.size() != 0) ? q0[0] : '0;
            #1;
            if (req0_valid && req0_ready) begin
                @(posedge clk);
                void'(q0.pop_front());
            end
        end
    end

    initial begin
        req1_valid = 1'b0;
        req1_addr  = '0;
        forever begin
            @(negedge clk);
            req1_valid = (q1.size() != 0);
            req1_addr  = (q1.size() != 0) ? q1[0] : '0;
            #1;
            if (req1_valid && req1_ready) begin
                @(posedge clk);
                void'(q1.pop_front());
            end
        end
    end

    // engine model: data is fixed or {addr[7:0], addr[15:8]}
    initial begin
        fr_done  = 1'b0;
        fr_data1 = '0;
        fr_data2 = '0;
        forever begin
            @(negedge clk);
            if (fr_start) begin
                eng_busy = 1;
                eng_a    = fr_addr;
                repeat (eng_lat) @(negedge clk);
                fr_data1 = eng_fixed ? eng_d1 : eng_a[7:0];
                fr_data2 = eng_fixed ? eng_d2 : eng_a[15:8];
                fr_done  = 1'b1;
                rise_log.push_back(cyc);
                repeat (eng_hold) @(negedge clk);
                fr_done = 1'b0;
                fall_log.push_back(cyc);
                eng_busy = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rsp0_valid) begin
            rsp0_n++;
            rsp0_last     = rsp0_data;
            rsp0_err_last = rsp0_err;
            rsp0_cyc      = cyc;
        end
        if (rsp1_valid) begin
            rsp1_n++;
            rsp1_last     = rsp1_data;
            rsp1_err_last = rsp1_err;
            rsp1_cyc      = cyc;
        end
        if (fr_start) begin
            start_n++;
            addr_log.push_back(fr_addr);
            grant_log.push_back(grant);
            start_cyc_log.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "global timeout");
    end

    task automatic test_reset();
        arstn = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (fr_start !== 1'b0) begin bad++; $display("FAIL reset_fr_start: got %b want 0", fr_start); end
        total++; if (fr_addr !== '0) begin bad++; $display("FAIL reset_fr_addr: got %h want 000000", fr_addr); end
        total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
        total++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid}); end
        total++; if ({rsp1_data, rsp0_data} !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", {rsp1_data, rsp0_data}); end
        total++; if ({rsp1_err, rsp0_err} !== 2'b00) begin bad++; $display("FAIL reset_rsp_err: got %b want 00", {rsp1_err, rsp0_err}); end
        total++; if ({busy, grant} !== 2'b00) begin bad++; $display("FAIL reset_busy_grant: got %b want 00", {busy, grant}); end
        arstn = 1'b0;
    endtask

    task automatic test_simultaneous();
        int b, r0, r1;
        b  = addr_log.size();
        r0 = rsp0_n;
        r1 = rsp1_n;
        eng_fixed = 0; eng_lat = 5; eng_hold = 2;
        q0.push_back(24'h000100);
        q1.push_back(24'hBBDDFF);
        for (int i = 0; i < 400 && ((rsp0_n - r0) + (rsp1_n - r1)) < 2; i++) @(negedge clk);
        for (int i = 0; i < 300 && (busy || eng_busy); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        total++;
        if (addr_log.size() != b + 2) begin
            bad++; $display("FAIL sim_start_count: got %0d want 2", addr_log.size() - b);
        end else begin
            total++; if (addr_log[b] !== 24'h000100 || addr_log[b+1] !== 24'hBBDDFF) begin
                bad++; $display("FAIL sim_addr_order: got %h,%h want 000100,bbddff", addr_log[b], addr_log[b+1]);
            end
            total++; if (grant_log[b] !== 1'b0 || grant_log[b+1] !== 1'b1) begin
                bad++; $display("FAIL sim_grant_order: got %b,%b want 0,1", grant_log[b], grant_log[b+1]);
            end
        end
        total++; if ((rsp0_n - r0) != 1 || (rsp1_n - r1) != 1) begin bad++; $display("FAIL sim_rsp_count: got %0d,%0d want 1,1", rsp0_n - r0, rsp1_n - r1); end
        total++; if (rsp0_last !== 16'h0001) begin bad++; $display("FAIL sim_rsp0_data: got %h want 0001", rsp0_last); end
        total++; if (rsp1_last !== 16'hFFDD) begin bad++; $display("FAIL sim_rsp1_data: got %h want ffdd", rsp1_last); end
        total++; if (rsp0_data !== 16'h0001) begin bad++; $display("FAIL sim_rsp0_held: got %h want 0001", rsp0_data); end
    endtask

    task automatic test_fairness();
        int b, r0, r1;
        logic [AW-1:0] exp_addr [6];
        exp_addr = '{24'h000010, 24'h000020, 24'h000011, 24'h000021, 24'h000012, 24'h000022};
        b  = addr_log.size();
        r0 = rsp0_n;
        r1 = rsp1_n;
        eng_fixed = 0; eng_lat = 4; eng_hold = 2;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(24'h000010 + AW'(i));
            q1.push_back(24'h000020 + AW'(i));
        end
        for (int i = 0; i < 1000 && ((rsp0_n - r0) + (rsp1_n - r1)) < 6; i++) @(negedge clk);
        for (int i = 0; i < 300 && (busy || eng_busy); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        total++;
        if (addr_log.size() != b + 6) begin
            bad++; $display("FAIL fair_start_count: got %0d want 6", addr_log.size() - b);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (grant_log[b+i] !== 1'(i % 2) || addr_log[b+i] !== exp_addr[i]) begin
                    bad++; $display("FAIL fair_txn%0d: got grant %b addr %h want grant %0d addr %h", i, grant_log[b+i], addr_log[b+i], i % 2, exp_addr[i]);
                end
            end
        end
        total++; if ((rsp0_n - r0) != 3 || (rsp1_n - r1) != 3) begin bad++; $display("FAIL fair_rsp_count: got %0d,%0d want 3,3", rsp0_n - r0, rsp1_n - r1); end
        total++; if (rsp1_last !== 16'h2200) begin bad++; $display("FAIL fair_rsp1_last: got %h want 2200", rsp1_last); end
    endtask

    task automatic test_single_read();
        int b, r0, r1, rs;
        b  = addr_log.size();
        r0 = rsp0_n;
        r1 = rsp1_n;
        rs = rise_log.size();
        eng_fixed = 1; eng_d1 = 8'h5A; eng_d2 = 8'hC3; eng_lat = 40; eng_hold = 3;
        q0.push_back(24'hAACCEE);
        for (int i = 0; i < 300 && (rsp0_n - r0) < 1; i++) @(negedge clk);
        for (int i = 0; i < 300 && (busy || eng_busy); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++; if (addr_log.size() != b + 1) begin bad++; $display("FAIL single_start_count: got %0d want 1", addr_log.size() - b); end
        total++; if (fr_addr !== 24'hAACCEE) begin bad++; $display("FAIL single_fr_addr: got %h want aaccee", fr_addr); end
        total++; if ((rsp0_n - r0) != 1) begin bad++; $display("FAIL single_rsp0_count: got %0d want 1", rsp0_n - r0); end
        total++; if (rsp0_last !== 16'h5AC3 || rsp0_err_last !== 1'b0) begin bad++; $display("FAIL single_rsp0: got data %h err %b want 5ac3 0", rsp0_last, rsp0_err_last); end
        total++; if ((rsp1_n - r1) != 0) begin bad++; $display("FAIL single_rsp1_quiet: got %0d pulses want 0", rsp1_n - r1); end
        total++;
        if (rise_log.size() != rs + 1) begin
            bad++; $display("FAIL single_done_seen: got %0d rises want 1", rise_log.size() - rs);
        end else begin
            total++; if (rsp0_cyc - rise_log[rs] != 1) begin bad++; $display("FAIL single_rsp_latency: got %0d want 1", rsp0_cyc - rise_log[rs]); end
        end
        eng_fixed = 0;
    endtask

    task automatic test_done_held();
        int b, r0, r1, f0, s0;
        b  = addr_log.size();
        r0 = rsp0_n;
        r1 = rsp1_n;
        f0 = fall_log.size();
        s0 = start_n;
        eng_fixed = 0; eng_lat = 3; eng_hold = 50;
        q0.push_back(24'h000A01);
        for (int i = 0; i < 50 && start_n == s0; i++) @(negedge clk);
        q1.push_back(24'h000B01);
        for (int i = 0; i < 400 && (rsp1_n - r1) < 1; i++) @(negedge clk);
        for (int i = 0; i < 300 && (busy || eng_busy); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        total++;
        if (addr_log.size() != b + 2 || fall_log.size() < f0 + 1) begin
            bad++; $display("FAIL held_start_count: got %0d starts %0d falls want 2,>=1", addr_log.size() - b, fall_log.size() - f0);
        end else begin
            total++; if (start_cyc_log[b+1] - fall_log[f0] != 2) begin
                bad++; $display("FAIL held_restart_gap: got %0d want 2", start_cyc_log[b+1] - fall_log[f0]);
            end
            total++; if (addr_log[b+1] !== 24'h000B01) begin bad++; $display("FAIL held_second_addr: got %h want 000b01", addr_log[b+1]); end
        end
        total++; if ((rsp0_n - r0) != 1 || rsp0_last !== 16'h010A) begin bad++; $display("FAIL held_rsp0: got %0d pulses data %h want 1 010a", rsp0_n - r0, rsp0_last); end
        total++; if ((rsp1_n - r1) != 1 || rsp1_last !== 16'h010B) begin bad++; $display("FAIL held_rsp1: got %0d pulses data %h want 1 010b", rsp1_n - r1, rsp1_last); end
        total++; if (rsp0_data !== 16'h010A) begin bad++; $display("FAIL held_rsp0_unchanged: got %h want 010a", rsp0_data); end
    endtask

    task automatic test_reset_mid();
        int r0, r1, s0;
        r0 = rsp0_n;
        r1 = rsp1_n;
        s0 = start_n;
        eng_fixed = 0; eng_lat = 40; eng_hold = 2;
        q0.push_back(24'h000C01);
        for (int i = 0; i < 50 && start_n == s0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        #2 arstn = 1'b1;
        #1;
        total++; if ({busy, grant, fr_start} !== 3'b000) begin bad++; $display("FAIL rmid_busy_grant_start: got %b want 000", {busy, grant, fr_start}); end
        total++; if (fr_addr !== '0) begin bad++; $display("FAIL rmid_fr_addr: got %h want 000000", fr_addr); end
        total++; if ({rsp1_data, rsp0_data} !== 32'h0) begin bad++; $display("FAIL rmid_rsp_data: got %h want 0", {rsp1_data, rsp0_data}); end
        repeat (2) @(negedge clk);
        arstn = 1'b0;
        for (int i = 0; i < 200 && eng_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++; if (rsp0_n != r0 || rsp1_n != r1) begin bad++; $display("FAIL rmid_no_rsp: got %0d,%0d pulses want 0,0", rsp0_n - r0, rsp1_n - r1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle_after: got busy %b want 0", busy); end
        eng_lat = 6;
        q0.push_back(24'h000D01);
        for (int i = 0; i < 200 && rsp0_n == r0; i++) @(negedge clk);
        for (int i = 0; i < 300 && (busy || eng_busy); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        total++; if ((rsp0_n - r0) != 1 || rsp0_last !== 16'h010D || rsp0_err_last !== 1'b0) begin
            bad++; $display("FAIL rmid_fresh_read: got %0d pulses data %h err %b want 1 010d 0", rsp0_n - r0, rsp0_last, rsp0_err_last);
        end
    endtask

    task automatic test_timeout();
        bit early;
        @(negedge clk);
        t_req0_addr  = 24'h123456;
        t_req0_valid = 1'b1;
        #1;
        total++; if (t_req0_ready !== 1'b1) begin bad++; $display("FAIL to_accept: got ready %b want 1", t_req0_ready); end
        @(posedge clk);
        #1 t_req0_valid = 1'b0;
        @(negedge clk);
        total++; if (t_fr_start !== 1'b1 || t_fr_addr !== 24'h123456) begin bad++; $display("FAIL to_start: got %b %h want 1 123456", t_fr_start, t_fr_addr); end
        // 16 WAIT_DONE cycles follow the START cycle, response in the 17th
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (t_rsp0_valid || t_rsp1_valid) early = 1;
        end
        total++; if (early) begin bad++; $display("FAIL to_early: got early response want none"); end
        @(negedge clk);
        total++; if (t_rsp0_valid !== 1'b1 || t_rsp0_err !== 1'b1 || t_rsp0_data !== 16'h0000) begin
            bad++; $display("FAIL to_rsp: got valid %b err %b data %h want 1 1 0000", t_rsp0_valid, t_rsp0_err, t_rsp0_data);
        end
        total++; if (t_rsp1_valid !== 1'b0) begin bad++; $display("FAIL to_rsp1_quiet: got %b want 0", t_rsp1_valid); end
        @(negedge clk);
        total++; if (t_rsp0_valid !== 1'b0 || t_busy !== 1'b0) begin bad++; $display("FAIL to_after: got valid %b busy %b want 0 0", t_rsp0_valid, t_busy); end
        t_req0_addr  = 24'h654321;
        t_req0_valid = 1'b1;
        #1;
        total++; if (t_req0_ready !== 1'b1) begin bad++; $display("FAIL to_next_accept: got ready %b want 1", t_req0_ready); end
        @(posedge clk);
        #1 t_req0_valid = 1'b0;
        @(negedge clk);
        total++; if (t_fr_start !== 1'b1 || t_fr_addr !== 24'h654321) begin bad++; $display("FAIL to_next_start: got %b %h want 1 654321", t_fr_start, t_fr_addr); end
        repeat (25) @(negedge clk);
    endtask

    initial begin
        arstn        = 1'b1;
        t_req0_valid = 1'b0;
        t_req1_valid = 1'b0;
        t_req0_addr  = '0;
        t_req1_addr  = '0;
        t_fr_done    = 1'b0;
        t_fr_data1   = 8'hFF;
        t_fr_data2   = 8'hFF;
        test_reset();
        repeat (2) @(negedge clk);
        test_simultaneous();
        test_fairness();
        test_single_read();
        test_done_held();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
